// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at the accepting edge into shadow registers and made
// visible after a fixed latency, so HI/LO only change at commit or MTHI/MTLO.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_NONE7 = 3'd7
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        shi_q, shi_d, slo_q, slo_d;
   logic [31:0]        hi_q, hi_d, lo_q, lo_d;
   logic [31:0]        res_hi, res_lo;
   logic [63:0]        a_sx, b_sx, prod_s, prod_u;
   logic signed [31:0] a_s, b_s, quot_s, rem_s;
   logic               div_zero, div_ovf, can_accept;
   op_e                op_c;

   assign op_c = op_e'(op);

   // Combinational arithmetic for the operation presented this cycle
   always_comb begin
      a_sx     = {{32{A[31]}}, A};
      b_sx     = {{32{B[31]}}, B};
      prod_s   = a_sx * b_sx;
      prod_u   = {32'd0, A} * {32'd0, B};
      a_s      = A;
      b_s      = B;
      div_zero = (B == '0);
      div_ovf  = (A == 32'h8000_0000) && (B == '1);
      quot_s   = '0;
      rem_s    = '0;
      if (!div_zero && !div_ovf) begin
         quot_s = a_s / b_s;
         rem_s  = a_s % b_s;
      end
      res_hi = '0;
      res_lo = '0;
      case (op_c)
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_DIV: begin
            if (div_zero) begin
               res_hi = A;
               res_lo = '1;
            end else if (div_ovf) begin
               res_hi = '0;
               res_lo = 32'h8000_0000;
            end else begin
               res_hi = rem_s;
               res_lo = quot_s;
            end
         end
         OP_DIVU: begin
            if (div_zero) begin
               res_hi = A;
               res_lo = '1;
            end else begin
               res_hi = A % B;
               res_lo = A / B;
            end
         end
         default: ;
      endcase
   end

   // Next-state logic: commit on the final RUN edge, accept new work when idle
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shi_d      = shi_q;
      slo_d      = slo_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      can_accept = 1'b0;
      case (state_q)
         ST_IDLE: can_accept = 1'b1;
         ST_RUN: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               hi_d       = shi_q;
               lo_d       = slo_q;
               state_d    = ST_IDLE;
               can_accept = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // The commit edge doubles as an accept edge so back-to-back ops lose no
      // cycle; a start here overrides the commit's state/counter updates.
      if (can_accept && start) begin
         case (op_c)
            OP_MULT, OP_MULTU: begin
               shi_d   = res_hi;
               slo_d   = res_lo;
               cnt_d   = CNT_MULT;
               state_d = ST_RUN;
            end
            OP_DIV, OP_DIVU: begin
               shi_d   = res_hi;
               slo_d   = res_lo;
               cnt_d   = CNT_DIV;
               state_d = ST_RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
         endcase
      end
   end

   // State and architectural registers, cleared asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shi_q   <= '0;
         slo_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shi_q   <= shi_d;
         slo_q   <= slo_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and random operations against a transaction-level model.
module tb_md_unit;

   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op    = 3'd0;
   logic [31:0] A     = '0;
   logic [31:0] B     = '0;
   logic        busy;
   logic [31:0] HI, LO;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_hi = '0, exp_lo = '0;
   logic [31:0] pend_hi = '0, pend_lo = '0;
   int unsigned pend_n = 0;

   md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference: HI/LO from architectural rules using wide integer arithmetic
   function automatic void ref_calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
      int     ia, ib;
      longint sa, sb, ma, mb, q, r;
      logic [63:0] p;
      hi = '0;
      lo = '0;
      ia = a;
      ib = b;
      sa = ia;
      sb = ib;
      case (o)
         3'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
         3'd2: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
         3'd3: begin
            if (b == 32'd0) begin
               hi = a; lo = 32'hFFFF_FFFF;
            end else begin
               ma = (sa < 0) ? -sa : sa;
               mb = (sb < 0) ? -sb : sb;
               q  = ma / mb;
               r  = ma - q * mb;
               if ((sa < 0) != (sb < 0)) q = -q;
               if (sa < 0) r = -r;
               lo = q[31:0];
               hi = r[31:0];
            end
         end
         3'd4: begin
            if (b == 32'd0) begin
               hi = a; lo = 32'hFFFF_FFFF;
            end else begin
               lo = a / b;
               hi = a - lo * b;
            end
         end
         default: ;
      endcase
   endfunction

   // Present one op for one edge; commit_now marks that this edge also commits
   task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit commit_now, input string tag);
      start = 1'b1; op = o; A = a; B = b;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0; A = $urandom; B = $urandom;
      if (commit_now) begin exp_hi = pend_hi; exp_lo = pend_lo; end
      if (o == 3'd5) exp_hi = a;
      else if (o == 3'd6) exp_lo = a;
      else if (o >= 3'd1 && o <= 3'd4) begin
         ref_calc(o, a, b, pend_hi, pend_lo);
         pend_n = (o <= 3'd2) ? MC : DC;
      end
      chk({tag, "_busy0"}, 32'(busy), (o >= 3'd1 && o <= 3'd4) ? 32'd1 : 32'd0);
      chk({tag, "_hi0"}, HI, exp_hi);
      chk({tag, "_lo0"}, LO, exp_lo);
   endtask

   // Remaining busy cycles before the commit edge; optional MTHI poke while busy
   task automatic wait_busy(input string tag, input int inject_at);
      for (int j = 1; j < int'(pend_n); j++) begin
         if (j == inject_at) begin start = 1'b1; op = 3'd5; A = 32'd1234; end
         @(posedge clk); #1;
         start = 1'b0; op = 3'd0;
         chk({tag, "_busy"}, 32'(busy), 32'd1);
         chk({tag, "_hi_hold"}, HI, exp_hi);
         chk({tag, "_lo_hold"}, LO, exp_lo);
      end
   endtask

   task automatic finish_op(input string tag);
      @(posedge clk); #1;
      exp_hi = pend_hi;
      exp_lo = pend_lo;
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      chk({tag, "_hi"}, HI, exp_hi);
      chk({tag, "_lo"}, LO, exp_lo);
   endtask

   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
      launch(o, a, b, 1'b0, tag);
      if (o >= 3'd1 && o <= 3'd4) begin
         wait_busy(tag, 0);
         finish_op(tag);
      end
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;

      // reset state
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      #10 reset = 1'b1;

      do_op(3'd1, 32'hFFFF_FFFE, 32'd3, "mult");
      do_op(3'd2, 32'hFFFF_FFFE, 32'd3, "multu");
      do_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div");
      do_op(3'd4, 32'd7, 32'd2, "divu");
      do_op(3'd4, 32'd5, 32'd0, "divu_zero");
      do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      do_op(3'd3, 32'hDEAD_BEEF, 32'd0, "div_zero");
      do_op(3'd3, 32'd7, 32'hFFFF_FFFE, "div_negb");
      do_op(3'd7, 32'h1111_1111, 32'd1, "nop7");
      do_op(3'd0, 32'h2222_2222, 32'd1, "nop0");

      // start during RUN is ignored; HI/LO hold until commit
      launch(3'd1, 32'd1000, 32'hFFFF_FFFD, 1'b0, "ign");
      wait_busy("ign", 2);
      finish_op("ign");
      do_op(3'd6, 32'd9, 32'd0, "mtlo");
      do_op(3'd5, 32'hCAFE_0001, 32'd0, "mthi");

      // back-to-back: second op accepted on the first op's commit edge
      launch(3'd1, 32'h0001_2345, 32'hFFFF_FFFA, 1'b0, "b2b1");
      wait_busy("b2b1", 0);
      launch(3'd2, 32'hF000_000F, 32'h8000_0001, 1'b1, "b2b2");
      wait_busy("b2b2", 0);
      finish_op("b2b2");

      // random mix
      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(1, 6));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
         do_op(ro, ra, rb, "rand");
      end

      // asynchronous reset mid-divide discards the pending result
      launch(3'd3, 32'd100, 32'd7, 1'b0, "rstrun");
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      exp_hi = '0;
      exp_lo = '0;
      chk("rstrun_busy", 32'(busy), 32'd0);
      chk("rstrun_hi", HI, 32'd0);
      chk("rstrun_lo", LO, 32'd0);
      @(posedge clk);
      #4 reset = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
         chk("post_rst_busy", 32'(busy), 32'd0);
         chk("post_rst_hi", HI, exp_hi);
         chk("post_rst_lo", LO, exp_lo);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
